// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-style LCD access path.
//   - lcd_state_e     : read-path FSM state encoding
//   - MODE_*          : read-request mode encodings
//   - LCD_*_CYC       : default bus timing in clk cycles at 50 MHz, shared
//                       with the LCD write path
//   - lcd_mode_norm() : folds the unused mode code onto a status read
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_EN_LO = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_e;

    localparam logic [1:0] MODE_STATUS = 2'b00;
    localparam logic [1:0] MODE_DATA   = 2'b01;
    localparam logic [1:0] MODE_POLL   = 2'b10;

    localparam int unsigned LCD_SETUP_CYC = 8;
    localparam int unsigned LCD_EN_HI_CYC = 25;
    localparam int unsigned LCD_EN_LO_CYC = 25;
    localparam logic [17:0] LCD_POLL_MAX  = 18'h3FFFF;

    // Code 11 has no meaning on the bus; it behaves exactly like a status read.
    function automatic logic [1:0] lcd_mode_norm(input logic [1:0] m);
        return (m == 2'b11) ? MODE_STATUS : m;
    endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// -----------------------------------------------------------------------------
// lcd_reader_if
// Request, LCD pin and status bundle for lcd_reader.
// Handshake: start is a single-cycle request; it is accepted only while
// busy=0, and is dropped (not queued) otherwise. Completion is reported by a
// one-cycle done pulse, during which rd_data and timeout are valid.
//   master : requester side (drives start/mode, supplies lcd_din)
//   slave  : lcd_reader side (drives LCD pins, status and state_dbg)
// -----------------------------------------------------------------------------
interface lcd_reader_if;
    import lcd_pkg::*;

    logic       start;
    logic [1:0] mode;
    logic [7:0] lcd_din;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       bus_oe;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       timeout;
    lcd_state_e state_dbg;

    modport master (
        output start, mode, lcd_din,
        input  LCD_RW, LCD_EN, LCD_RS, bus_oe, busy, done, rd_data, timeout,
               state_dbg
    );

    modport slave (
        input  start, mode, lcd_din,
        output LCD_RW, LCD_EN, LCD_RS, bus_oe, busy, done, rd_data, timeout,
               state_dbg
    );

endinterface

// File: rtl/lcd_reader.sv
// -----------------------------------------------------------------------------
// lcd_reader
// Performs one LCD read cycle (status or data register) or polls the busy
// flag until it clears, with programmable setup / EN-high / EN-low timing.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-low reset
//   bus  : lcd_reader_if.slave
//          start/mode/lcd_din in; LCD_RW/LCD_EN/LCD_RS/bus_oe to the panel;
//          busy/done/rd_data/timeout status; state_dbg exposes the FSM state.
// -----------------------------------------------------------------------------
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = LCD_SETUP_CYC,
    parameter int unsigned EN_HI_CYC = LCD_EN_HI_CYC,
    parameter int unsigned EN_LO_CYC = LCD_EN_LO_CYC,
    parameter logic [17:0] POLL_MAX  = LCD_POLL_MAX
) (
    input  logic         clk,
    input  logic         rst,
    lcd_reader_if.slave  bus
);

    // Terminal phase count of each timed state.
    localparam logic [5:0] SETUP_LAST = 6'(SETUP_CYC - 1);
    localparam logic [5:0] EN_HI_LAST = 6'(EN_HI_CYC - 1);
    localparam logic [5:0] EN_LO_LAST = 6'(EN_LO_CYC - 1);

    lcd_state_e  state_q, state_d;
    logic [5:0]  phase_q, phase_d;
    logic [17:0] poll_q, poll_d;
    logic [1:0]  mode_q, mode_d;
    logic        rs_q, rs_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        // The phase counter holds at all-ones rather than wrapping.
        phase_d   = (phase_q == 6'h3F) ? phase_q : phase_q + 6'd1;
        poll_d    = poll_q;
        mode_d    = mode_q;
        rs_d      = rs_q;
        rd_data_d = rd_data_q;
        // Only ever set on the transition into DONE, so it reads 1 solely
        // during the DONE cycle.
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETUP;
                    mode_d  = lcd_mode_norm(bus.mode);
                    rs_d    = (bus.mode == MODE_DATA);
                    poll_d  = '0;
                end
            end
            ST_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    state_d = ST_EN_HI;
                end
            end
            ST_EN_HI: begin
                if (phase_q == EN_HI_LAST) begin
                    state_d   = ST_EN_LO;
                    // Sample on the edge where EN falls.
                    rd_data_d = bus.lcd_din;
                end
            end
            ST_EN_LO: begin
                if (phase_q == EN_LO_LAST) begin
                    if ((mode_q == MODE_POLL) && rd_data_q[7] && (poll_q < POLL_MAX)) begin
                        poll_d  = poll_q + 18'd1;
                        state_d = ST_SETUP;
                    end else begin
                        state_d   = ST_DONE;
                        // Still busy on exit means the poll budget ran out.
                        timeout_d = (mode_q == MODE_POLL) && rd_data_q[7];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state change, including the poll loop back into SETUP,
        // restarts the phase timing.
        if (state_d != state_q) begin
            phase_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            poll_q    <= '0;
            mode_q    <= MODE_STATUS;
            rs_q      <= 1'b0;
            rd_data_q <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            poll_q    <= poll_d;
            mode_q    <= mode_d;
            rs_q      <= rs_d;
            rd_data_q <= rd_data_d;
            timeout_q <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state, so reset takes effect at the
    // same edge with no extra latency)
    // ------------------------------------------------------------------
    assign bus.LCD_RW    = (state_q == ST_SETUP) || (state_q == ST_EN_HI) ||
                           (state_q == ST_EN_LO);
    assign bus.LCD_EN    = (state_q == ST_EN_HI);
    assign bus.LCD_RS    = rs_q;
    assign bus.bus_oe    = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.rd_data   = rd_data_q;
    assign bus.timeout   = timeout_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_lcd_reader.sv
// -----------------------------------------------------------------------------
// tb_lcd_reader
// Directed bench for lcd_reader. dut0 uses default timing and poll budget;
// dut1 uses POLL_MAX=4 to reach the poll timeout quickly.
// -----------------------------------------------------------------------------
module tb_lcd_reader;
    import lcd_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    lcd_reader_if if0 ();
    lcd_reader_if if1 ();

    logic       sel     = 1'b0;
    logic       start_v = 1'b0;
    logic [1:0] mode_v  = 2'b00;
    logic [7:0] din_v   = 8'h00;

    assign if0.start   = start_v & ~sel;
    assign if1.start   = start_v & sel;
    assign if0.mode    = mode_v;
    assign if1.mode    = mode_v;
    assign if0.lcd_din = din_v;
    assign if1.lcd_din = din_v;

    lcd_reader u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    lcd_reader #(.POLL_MAX(18'd4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // View of whichever DUT is selected.
    logic       s_rw, s_en, s_rs, s_oe, s_busy, s_done, s_to;
    logic [7:0] s_rd;
    assign s_rw   = sel ? if1.LCD_RW  : if0.LCD_RW;
    assign s_en   = sel ? if1.LCD_EN  : if0.LCD_EN;
    assign s_rs   = sel ? if1.LCD_RS  : if0.LCD_RS;
    assign s_oe   = sel ? if1.bus_oe  : if0.bus_oe;
    assign s_busy = sel ? if1.busy    : if0.busy;
    assign s_done = sel ? if1.done    : if0.done;
    assign s_to   = sel ? if1.timeout : if0.timeout;
    assign s_rd   = sel ? if1.rd_data : if0.rd_data;

    // ------------------------------------------------------------------
    // Scoreboard: {timeout, rd_data}
    // ------------------------------------------------------------------
    logic [8:0] exp_q[$];
    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Driver: issue one request and monitor it to completion
    // ------------------------------------------------------------------
    task automatic run_xfer(
        input  logic       s,
        input  logic [1:0] m,
        input  logic [7:0] din_a,
        input  logic [7:0] din_b,
        input  int         flip_after,
        input  logic [8:0] exp,
        input  int         restart_at,
        output int         done_cyc,
        output int         pulses,
        output int         en_min,
        output int         en_max,
        output int         done_cnt,
        output logic       rs_bad,
        output logic       ctl_bad
    );
        int cyc;
        int cur_len;
        int extra;
        logic [8:0] e;
        logic rs_exp;
        done_cyc = 0; pulses = 0; en_min = 1000; en_max = 0; done_cnt = 0;
        rs_bad = 1'b0; ctl_bad = 1'b0; cur_len = 0; extra = 0;
        rs_exp = (m == MODE_DATA);
        sel    = s;
        mode_v = m;
        din_v  = din_a;
        exp_q.push_back(exp);
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        // The transfer must not notice later mode changes.
        mode_v  = ~m;
        cyc = 1;
        while (cyc < 2000 && extra < 70) begin
            start_v = 1'b0;
            if (s_en) begin
                cur_len++;
            end else if (cur_len > 0) begin
                pulses++;
                if (cur_len < en_min) en_min = cur_len;
                if (cur_len > en_max) en_max = cur_len;
                cur_len = 0;
                if (pulses == flip_after) din_v = din_b;
            end
            if (s_busy) begin
                if (s_rs !== rs_exp) rs_bad = 1'b1;
                if (s_done) begin
                    if (s_rw !== 1'b0 || s_en !== 1'b0 || s_oe !== 1'b0) ctl_bad = 1'b1;
                end else begin
                    if (s_rw !== 1'b1 || s_oe !== 1'b0) ctl_bad = 1'b1;
                end
            end else begin
                if (s_rw !== 1'b0 || s_en !== 1'b0 || s_oe !== 1'b1 || s_done !== 1'b0)
                    ctl_bad = 1'b1;
            end
            if (s_done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_result", {s_to, s_rd}, e);
                    end
                end
                // A start during DONE must be dropped as well.
                if (restart_at > 0) start_v = 1'b1;
            end
            if (cyc == restart_at) start_v = 1'b1;
            if (done_cyc > 0) extra++;
            tick();
            cyc++;
        end
        start_v = 1'b0;
        check("done_seen", done_cyc != 0, 1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int   dc, np, emin, emax, ndone;
        logic rsb, ctb;
        logic [7:0] rnd;
        int   wait_cnt;

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("rst_rw",      if0.LCD_RW,    0);
        check("rst_en",      if0.LCD_EN,    0);
        check("rst_rs",      if0.LCD_RS,    0);
        check("rst_oe",      if0.bus_oe,    1);
        check("rst_busy",    if0.busy,      0);
        check("rst_done",    if0.done,      0);
        check("rst_timeout", if0.timeout,   0);
        check("rst_rd",      if0.rd_data,   8'h00);
        check("rst_state",   if0.state_dbg, ST_IDLE);
        check("rst_state1",  if1.state_dbg, ST_IDLE);
        rst = 1'b1;
        tick();

        // Mode 01 data read of 0x48
        run_xfer(1'b0, MODE_DATA, 8'h48, 8'h48, 0, {1'b0, 8'h48}, 0,
                 dc, np, emin, emax, ndone, rsb, ctb);
        check("m01_done_cyc", dc, 59);
        check("m01_pulses",   np, 1);
        check("m01_en_min",   emin, 25);
        check("m01_en_max",   emax, 25);
        check("m01_ndone",    ndone, 1);
        check("m01_rs",       rsb, 0);
        check("m01_ctl",      ctb, 0);

        // Mode 10: busy flag set for three reads, then 0x05
        rnd = 8'h80 | 8'($urandom_range(0, 127));
        run_xfer(1'b0, MODE_POLL, rnd, 8'h05, 3, {1'b0, 8'h05}, 0,
                 dc, np, emin, emax, ndone, rsb, ctb);
        check("poll_pulses",   np, 4);
        check("poll_done_cyc", dc, 4 * 58 + 1);
        check("poll_en_min",   emin, 25);
        check("poll_en_max",   emax, 25);
        check("poll_rs",       rsb, 0);
        check("poll_ctl",      ctb, 0);

        // Mode 10 on the POLL_MAX=4 instance, busy flag stuck
        run_xfer(1'b1, MODE_POLL, 8'h80, 8'h80, 0, {1'b1, 8'h80}, 0,
                 dc, np, emin, emax, ndone, rsb, ctb);
        check("pto_pulses",   np, 5);
        check("pto_done_cyc", dc, 5 * 58 + 1);
        check("pto_ndone",    ndone, 1);
        check("pto_ctl",      ctb, 0);

        // Same instance, status read with BF=1: no timeout outside poll mode
        run_xfer(1'b1, MODE_STATUS, 8'h80, 8'h80, 0, {1'b0, 8'h80}, 0,
                 dc, np, emin, emax, ndone, rsb, ctb);
        check("st_bf_pulses", np, 1);
        check("st_bf_cyc",    dc, 59);

        // Second start at cycle 10 and during DONE: both ignored
        rnd = 8'($urandom_range(0, 255));
        run_xfer(1'b0, MODE_DATA, rnd, rnd, 0, {1'b0, rnd}, 10,
                 dc, np, emin, emax, ndone, rsb, ctb);
        check("rst_ign_cyc",    dc, 59);
        check("rst_ign_ndone",  ndone, 1);
        check("rst_ign_pulses", np, 1);
        check("rst_ign_busy",   if0.busy, 0);

        // Reset during EN_HI aborts with no done pulse
        sel = 1'b0; mode_v = MODE_DATA; din_v = 8'h33;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        wait_cnt = 0;
        while (!if0.LCD_EN && wait_cnt < 100) begin
            tick();
            wait_cnt++;
        end
        check("abort_en_seen", if0.LCD_EN, 1);
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_en",    if0.LCD_EN, 0);
        check("abort_rw",    if0.LCD_RW, 0);
        check("abort_oe",    if0.bus_oe, 1);
        check("abort_busy",  if0.busy,   0);
        check("abort_rs",    if0.LCD_RS, 0);
        ndone = 0;
        np = 0;
        repeat (80) begin
            tick();
            if (if0.done) ndone++;
            if (if0.LCD_EN) np++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_no_en",   np, 0);

        // start and reset in the same cycle: reset wins, nothing queued
        mode_v = MODE_DATA;
        rst = 1'b0;
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        rst = 1'b1;
        check("rst_start_busy", if0.busy, 0);
        tick();
        check("rst_start_busy2", if0.busy, 0);

        // Mode 00 status read of 0x2A
        run_xfer(1'b0, MODE_STATUS, 8'h2A, 8'h2A, 0, {1'b0, 8'h2A}, 0,
                 dc, np, emin, emax, ndone, rsb, ctb);
        check("m00_done_cyc", dc, 59);
        check("m00_rs",       rsb, 0);
        check("m00_rs_now",   if0.LCD_RS, 0);
        check("m00_ctl",      ctb, 0);

        // Mode 11 behaves as a status read
        rnd = 8'h80 | 8'($urandom_range(0, 127));
        run_xfer(1'b0, 2'b11, rnd, rnd, 0, {1'b0, rnd}, 0,
                 dc, np, emin, emax, ndone, rsb, ctb);
        check("m11_done_cyc", dc, 59);
        check("m11_pulses",   np, 1);
        check("m11_rs",       rsb, 0);

        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
